// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode and execute for the simple CPU datapath.
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted
);
    typedef enum logic [4:0] {
        RST, IF1, IF2, UPC, DEC, WIMM, GETA, GETB, ALU, CMPS,
        WRD, ADDR, LADR, MRD1, MRD2, GETD, SVAL, MWR, HALT
    } state_t;
    localparam logic [1:0] NONE = 2'b00, READ = 2'b01, WRITE = 2'b10;
    state_t state, nxt;
    logic [4:0] code;
    logic       ld_st;
    assign code  = {opcode, op};
    assign ld_st = opcode == 3'b011 || opcode == 3'b100;
    always_ff @(posedge clk) state <= reset ? RST : nxt;
    always_comb begin
        nxt       = RST;
        nsel      = 3'b000;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = NONE;
        halted    = 1'b0;
        case (state)
            RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                nxt      = IF1;
            end
            IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = READ;
                nxt      = IF2;
            end
            IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = READ;
                load_ir  = 1'b1;
                nxt      = UPC;
            end
            UPC: begin
                load_pc = 1'b1;
                nxt     = DEC;
            end
            // unrecognised codes fall back to IF1 as a NOP
            DEC: nxt = code == 5'b11010 ? WIMM :
                       (code == 5'b11000 || code == 5'b10111) ? GETB :
                       (opcode == 3'b101 || code == 5'b01100 || code == 5'b10000) ? GETA :
                       opcode == 3'b111 ? HALT : IF1;
            WIMM: begin
                nsel  = 3'b001;
                vsel  = 2'b10;
                write = 1'b1;
                nxt   = IF1;
            end
            GETA: begin
                nsel  = 3'b001;
                loada = 1'b1;
                nxt   = ld_st ? ADDR : GETB;
            end
            GETB: begin
                nsel  = 3'b100;
                loadb = 1'b1;
                nxt   = code == 5'b10101 ? CMPS : ALU;
            end
            ALU: begin
                loadc = 1'b1;
                asel  = code == 5'b11000 || code == 5'b10111;
                nxt   = WRD;
            end
            CMPS: begin
                loads = 1'b1;
                nxt   = IF1;
            end
            WRD: begin
                nsel  = 3'b010;
                write = 1'b1;
                nxt   = IF1;
            end
            ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
                nxt   = LADR;
            end
            LADR: begin
                load_addr = 1'b1;
                nxt       = opcode == 3'b011 ? MRD1 : GETD;
            end
            MRD1: begin
                mem_cmd = READ;
                nxt     = MRD2;
            end
            MRD2: begin
                mem_cmd = READ;
                nsel    = 3'b010;
                vsel    = 2'b11;
                write   = 1'b1;
                nxt     = IF1;
            end
            GETD: begin
                nsel  = 3'b010;
                loadb = 1'b1;
                nxt   = SVAL;
            end
            SVAL: begin
                asel  = 1'b1;
                loadc = 1'b1;
                nxt   = MWR;
            end
            MWR: begin
                mem_cmd = WRITE;
                nxt     = IF1;
            end
            HALT: begin
                halted = 1'b1;
                nxt    = HALT;
            end
            default: nxt = RST;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: per-instruction expected output sequences checked against cpu_controller.
module tb_cpu_controller;
    logic       clk, reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel, mem_cmd;
    logic       loada, loadb, loadc, loads, write, asel, bsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
    logic [19:0] obs;
    logic [19:0] q[$];
    logic [4:0]  codes[12];
    int checks = 0, errors = 0;

    cpu_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .write(write), .asel(asel), .bsel(bsel), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
        .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign obs = {nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                  load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted};

    // {nsel, vsel, {la,lb,lc,ls,wr,as,bs}, {ir,lpc,rpc,laddr,asel_pc}, mem_cmd, halted}
    localparam logic [19:0] S_RST  = {3'b000, 2'b00, 7'b0000000, 5'b01100, 2'b00, 1'b0};
    localparam logic [19:0] S_IF1  = {3'b000, 2'b00, 7'b0000000, 5'b00001, 2'b01, 1'b0};
    localparam logic [19:0] S_IF2  = {3'b000, 2'b00, 7'b0000000, 5'b10001, 2'b01, 1'b0};
    localparam logic [19:0] S_UPC  = {3'b000, 2'b00, 7'b0000000, 5'b01000, 2'b00, 1'b0};
    localparam logic [19:0] S_DEC  = 20'h0;
    localparam logic [19:0] S_WIMM = {3'b001, 2'b10, 7'b0000100, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_GETA = {3'b001, 2'b00, 7'b1000000, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_GETB = {3'b100, 2'b00, 7'b0100000, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_ALU  = {3'b000, 2'b00, 7'b0010000, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_ALUZ = {3'b000, 2'b00, 7'b0010010, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_CMPS = {3'b000, 2'b00, 7'b0001000, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_WRD  = {3'b010, 2'b00, 7'b0000100, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_ADDR = {3'b000, 2'b00, 7'b0010001, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_LADR = {3'b000, 2'b00, 7'b0000000, 5'b00010, 2'b00, 1'b0};
    localparam logic [19:0] S_MRD1 = {3'b000, 2'b00, 7'b0000000, 5'b00000, 2'b01, 1'b0};
    localparam logic [19:0] S_MRD2 = {3'b010, 2'b11, 7'b0000100, 5'b00000, 2'b01, 1'b0};
    localparam logic [19:0] S_GETD = {3'b010, 2'b00, 7'b0100000, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_SVAL = {3'b000, 2'b00, 7'b0010010, 5'b00000, 2'b00, 1'b0};
    localparam logic [19:0] S_MWR  = {3'b000, 2'b00, 7'b0000000, 5'b00000, 2'b10, 1'b0};
    localparam logic [19:0] S_HALT = {3'b000, 2'b00, 7'b0000000, 5'b00000, 2'b00, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [19:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert (!(write === 1'b1 && mem_cmd === 2'b10)) else begin
            errors++;
            $error("FAIL %s write_with_memwrite observed=1 expected=0", tag);
        end
    endtask

    // instruction class -> cycle-by-cycle expected outputs, starting at fetch
    task automatic build(input logic [2:0] oc, input logic [1:0] p);
        logic [4:0] c;
        c = {oc, p};
        q = {S_IF1, S_IF2, S_UPC, S_DEC};
        if (c == 5'b11010) q.push_back(S_WIMM);
        else if (c == 5'b11000 || c == 5'b10111) q = {q, S_GETB, S_ALUZ, S_WRD};
        else if (oc == 3'b101) q = p == 2'b01 ? {q, S_GETA, S_GETB, S_CMPS} : {q, S_GETA, S_GETB, S_ALU, S_WRD};
        else if (c == 5'b01100) q = {q, S_GETA, S_ADDR, S_LADR, S_MRD1, S_MRD2};
        else if (c == 5'b10000) q = {q, S_GETA, S_ADDR, S_LADR, S_GETD, S_SVAL, S_MWR};
        else if (oc == 3'b111) for (int i = 0; i < 22; i++) q.push_back(S_HALT);
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        chk(S_RST, "reset_pulse");
        reset = 0;
        tick();
    endtask

    // k=0 runs to completion; k>0 pulses reset during step k; k<0 picks k at random
    task automatic run(input logic [2:0] oc, input logic [1:0] p, input int k);
        int lim;
        opcode = oc;
        op = p;
        build(oc, p);
        if (k < 0) k = $urandom_range(1, q.size() - 1);
        lim = k == 0 ? q.size() : k + 1;
        for (int i = 0; i < lim; i++) begin
            chk(q[i], $sformatf("instr_%b_%b_step%0d", oc, p, i));
            if (k == 0 || i < k) tick();
        end
        if (k != 0 || oc == 3'b111) do_reset();
    endtask

    initial begin
        logic [4:0] c;
        codes = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10101, 5'b10110,
                  5'b01100, 5'b10000, 5'b01000, 5'b00011, 5'b01101, 5'b10001};
        reset = 1;
        opcode = 0;
        op = 0;
        tick();
        chk(S_RST, "reset_hold0");
        tick();
        chk(S_RST, "reset_hold1");
        reset = 0;
        chk(S_RST, "reset_release");
        tick();
        run(3'b110, 2'b10, 0);
        run(3'b101, 2'b00, 0);
        run(3'b011, 2'b00, 0);
        run(3'b100, 2'b00, 0);
        run(3'b101, 2'b01, 0);
        run(3'b010, 2'b00, 0);
        run(3'b110, 2'b00, 0);
        run(3'b101, 2'b11, 0);
        run(3'b101, 2'b10, 0);
        run(3'b111, 2'b01, 0);
        run(3'b011, 2'b00, 7);
        run(3'b100, 2'b00, 8);
        for (int n = 0; n < 80; n++) begin
            c = codes[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) c = {3'b111, 2'($urandom_range(0, 3))};
            run(c[4:2], c[1:0], $urandom_range(0, 5) == 0 ? -1 : 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
